// File: rtl/bus2_line_master_if.sv
`default_nettype none
// ============================================================================
// Module   : bus2_line_master_if
// Purpose  : Whole-line request/response handshake between cache core and
//            bus2_line_master.
// Revision : 1.0  initial release
// ============================================================================
interface bus2_line_master_if #(
    parameter int ADDR2_BUS_SIZE  = 14,
    parameter int CACHE_LINE_SIZE = 16
);
    logic                         req_valid;
    logic                         req_write;
    logic [ADDR2_BUS_SIZE-1:0]    req_addr;
    logic [CACHE_LINE_SIZE*8-1:0] req_wdata;
    logic                         req_ready;
    logic                         resp_valid;
    logic                         resp_error;
    logic [CACHE_LINE_SIZE*8-1:0] resp_rdata;

    // master = cache core issuing requests, slave = the line master serving them
    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_error, resp_rdata
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_error, resp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/bus2_line_master.sv
`default_nettype none
// ============================================================================
// Module   : bus2_line_master
// Purpose  : Converts one cache-line read/write request into a bus2
//            command/address/data sequence, supervised by a watchdog.
// Revision : 1.0  initial release
// ============================================================================
module bus2_line_master #(
    parameter int ADDR2_BUS_SIZE  = 14,
    parameter int DATA_BUS_SIZE   = 16,
    parameter int CTR2_BUS_SIZE   = 2,
    parameter int CACHE_LINE_SIZE = 16,
    parameter int C2_NOP          = 0,
    parameter int C2_RESPONSE     = 1,
    parameter int C2_READ_LINE    = 2,
    parameter int C2_WRITE_LINE   = 3,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  wire                      CLK,
    input  wire                      RESET,
    bus2_line_master_if.slave        req_if,
    inout  wire [ADDR2_BUS_SIZE-1:0] A2_WIRE,
    inout  wire [DATA_BUS_SIZE-1:0]  D2_WIRE,
    inout  wire [CTR2_BUS_SIZE-1:0]  C2_WIRE
);
    localparam int c_LINE_BITS = CACHE_LINE_SIZE * 8;
    localparam int c_BEATS     = c_LINE_BITS / DATA_BUS_SIZE;
    localparam int c_BEAT_W    = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_WD_W      = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_BEAT_W-1:0]      c_BEAT_LAST = c_BEAT_W'(c_BEATS - 1);
    localparam logic [c_BEAT_W-1:0]      c_BEAT_ONE  = c_BEAT_W'(1);
    localparam logic [c_WD_W-1:0]        c_WD_LAST   = c_WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_WD_W-1:0]        c_WD_ONE    = c_WD_W'(1);
    localparam logic [CTR2_BUS_SIZE-1:0] c_C2_NOP    = CTR2_BUS_SIZE'(C2_NOP);
    localparam logic [CTR2_BUS_SIZE-1:0] c_C2_RESP   = CTR2_BUS_SIZE'(C2_RESPONSE);
    localparam logic [CTR2_BUS_SIZE-1:0] c_C2_READ   = CTR2_BUS_SIZE'(C2_READ_LINE);
    localparam logic [CTR2_BUS_SIZE-1:0] c_C2_WRITE  = CTR2_BUS_SIZE'(C2_WRITE_LINE);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_CMD  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_RD_DATA = 3'd3,
        S_WR_DATA = 3'd4,
        S_WR_WAIT = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [ADDR2_BUS_SIZE-1:0]  r_addr;
    logic [c_LINE_BITS-1:0]     r_wdata;
    logic [c_LINE_BITS-1:0]     r_rdata;
    logic [c_BEAT_W-1:0]        r_beat;
    logic [c_WD_W-1:0]          r_wd_cnt;
    logic                       r_resp_valid;
    logic                       r_resp_error;

    logic                       w_c2_en;
    logic                       w_a2_en;
    logic                       w_d2_en;
    logic [CTR2_BUS_SIZE-1:0]   w_c2_val;
    logic [DATA_BUS_SIZE-1:0]   w_wbeat;
    logic                       w_c2_resp;
    logic                       w_in_wait;
    logic                       w_wd_expire;

    assign w_c2_resp   = (C2_WIRE == c_C2_RESP);
    assign w_in_wait   = (r_state == S_RD_WAIT) || (r_state == S_WR_WAIT);
    assign w_wd_expire = (r_wd_cnt == c_WD_LAST);
    assign w_wbeat     = r_wdata[int'(r_beat) * DATA_BUS_SIZE +: DATA_BUS_SIZE];

    // Enables decode straight from the state register so reset releases the bus at once
    assign C2_WIRE = w_c2_en ? w_c2_val : {CTR2_BUS_SIZE{1'bz}};
    assign A2_WIRE = w_a2_en ? r_addr   : {ADDR2_BUS_SIZE{1'bz}};
    assign D2_WIRE = w_d2_en ? w_wbeat  : {DATA_BUS_SIZE{1'bz}};

    assign req_if.req_ready  = (r_state == S_IDLE);
    assign req_if.resp_valid = r_resp_valid;
    assign req_if.resp_error = r_resp_error;
    assign req_if.resp_rdata = r_rdata;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_c2_en     = 1'b0;
        w_a2_en     = 1'b0;
        w_d2_en     = 1'b0;
        w_c2_val    = c_C2_NOP;
        case (r_state)
            S_IDLE: begin
                if (req_if.req_valid) begin
                    w_state_nxt = req_if.req_write ? S_WR_DATA : S_RD_CMD;
                end
            end
            S_RD_CMD: begin
                w_c2_en     = 1'b1;
                w_a2_en     = 1'b1;
                w_c2_val    = c_C2_READ;
                w_state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (w_c2_resp) begin
                    w_state_nxt = S_RD_DATA;
                end else if (w_wd_expire) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_RD_DATA: begin
                if (r_beat == c_BEAT_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_WR_DATA: begin
                w_c2_en  = 1'b1;
                w_a2_en  = 1'b1;
                w_d2_en  = 1'b1;
                w_c2_val = c_C2_WRITE;
                if (r_beat == c_BEAT_LAST) begin
                    w_state_nxt = S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (w_c2_resp || w_wd_expire) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_beat       <= '0;
            r_wd_cnt     <= '0;
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
        end else begin
            r_resp_valid <= (w_state_nxt == S_DONE);
            // Only a wait state can reach DONE without a RESPONSE: that is the timeout
            r_resp_error <= (w_state_nxt == S_DONE) && w_in_wait && !w_c2_resp;

            if (w_in_wait) begin
                if (!w_wd_expire) begin
                    r_wd_cnt <= r_wd_cnt + c_WD_ONE;
                end
            end else begin
                r_wd_cnt <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (req_if.req_valid) begin
                        r_addr  <= req_if.req_addr;
                        r_wdata <= req_if.req_wdata;
                        r_rdata <= '0;
                        r_beat  <= '0;
                    end
                end
                S_RD_WAIT: begin
                    if (w_c2_resp) begin
                        r_rdata[0 +: DATA_BUS_SIZE] <= D2_WIRE;
                        r_beat                      <= c_BEAT_ONE;
                    end
                end
                S_RD_DATA: begin
                    r_rdata[int'(r_beat) * DATA_BUS_SIZE +: DATA_BUS_SIZE] <= D2_WIRE;
                    r_beat <= (r_beat == c_BEAT_LAST) ? '0 : r_beat + c_BEAT_ONE;
                end
                S_WR_DATA: begin
                    r_beat <= (r_beat == c_BEAT_LAST) ? '0 : r_beat + c_BEAT_ONE;
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire
